// File: rtl/mux4_pkg.sv
// Shared types for the mux4 arbitration stages: select index, request vector and arbiter states.
package mux4_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] sel_t;
  typedef logic [3:0] req_vec_t;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_e;

  function automatic req_vec_t onehot(input sel_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first requester at or after ptr, wrapping modulo 4.
module rr_pick4
  import mux4_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output sel_t     winner,
  output logic     any
);

  always_comb begin
    winner = ptr;
    any    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // 2-bit addition wraps the scan back to requester 0 for free
      if (!any && req[ptr + sel_t'(k)]) begin
        winner = ptr + sel_t'(k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin, packet-locked arbiter driving mux4 sel, with a valid/ready handshake on the shared path.
module mux4_rr_arbiter
  import mux4_pkg::*;
#(
  parameter int PRIO_RESET = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  req_vec_t req,
  input  req_vec_t last,
  output req_vec_t gnt,
  output sel_t     sel,
  output logic     out_valid,
  output logic     out_last,
  input  logic     out_ready,
  output logic     busy
);

  arb_state_e state, next_state;
  req_vec_t   next_gnt;
  sel_t       next_sel, ptr, next_ptr, winner;
  logic       any, accept;

  rr_pick4 u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any)
  );

  assign busy      = (state == GRANT);
  assign out_valid = req[sel] & busy;
  assign out_last  = last[sel] & out_valid;
  assign accept    = out_valid & out_ready;

  // Arbitration only happens from IDLE, which yields the one bubble cycle after each packet.
  always_comb begin
    next_state = state;
    next_gnt   = gnt;
    next_sel   = sel;
    next_ptr   = ptr;
    case (state)
      IDLE: begin
        if (any) begin
          next_state = GRANT;
          next_gnt   = onehot(winner);
          next_sel   = winner;
        end
      end
      GRANT: begin
        if (accept && out_last) begin
          next_state = IDLE;
          next_gnt   = '0;
          next_ptr   = sel + sel_t'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= sel_t'(PRIO_RESET);
    end else begin
      state <= next_state;
      gnt   <= next_gnt;
      sel   <= next_sel;
      ptr   <= next_ptr;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_busy    : assert property (@(posedge clk) disable iff (rst) (gnt == '0) == !busy);
  a_gnt_sel     : assert property (@(posedge clk) disable iff (rst) busy |-> (gnt == onehot(sel)));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: hand-derived vector table, then random traffic against a reference model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  // reference model: who owns the path, last owner index, and the next start of the priority scan
  bit m_busy;
  int m_sel;
  int m_ptr;

  typedef struct {
    string      name;
    bit         rst;
    logic [3:0] req;
    logic [3:0] last;
    bit         ready;
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    bit         exp_busy;
    bit         exp_valid;
    bit         exp_last;
  } vec_t;

  vec_t vecs[$];

  mux4_rr_arbiter #(.PRIO_RESET(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input bit r, input logic [3:0] q, input logic [3:0] l, input bit rd);
    rst       = r;
    req       = q;
    last      = l;
    out_ready = rd;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg, input logic [1:0] es,
                             input bit eb, input bit ev, input bit el);
    compared += 5;
    if (gnt !== eg) begin
      mismatched++;
      $display("[TB] FAIL %s.gnt got %b want %b", name, gnt, eg);
    end
    if (sel !== es) begin
      mismatched++;
      $display("[TB] FAIL %s.sel got %0d want %0d", name, sel, es);
    end
    if (busy !== eb) begin
      mismatched++;
      $display("[TB] FAIL %s.busy got %b want %b", name, busy, eb);
    end
    if (out_valid !== ev) begin
      mismatched++;
      $display("[TB] FAIL %s.out_valid got %b want %b", name, out_valid, ev);
    end
    if (out_last !== el) begin
      mismatched++;
      $display("[TB] FAIL %s.out_last got %b want %b", name, out_last, el);
    end
  endtask

  task automatic checkModel(input string name);
    logic [3:0] eg;
    bit         ev;
    eg = m_busy ? (4'd1 << m_sel) : 4'd0;
    ev = m_busy && req[m_sel];
    checkOutput(name, eg, 2'(m_sel), m_busy, ev, ev && last[m_sel]);
  endtask

  // next state of the model from the inputs currently applied, then move to the next cycle
  task automatic advance();
    if (rst) begin
      m_busy = 1'b0;
      m_sel  = 0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && req[(m_ptr + k) % 4]) begin
          m_busy = 1'b1;
          m_sel  = (m_ptr + k) % 4;
        end
      end
    end else if (req[m_sel] && out_ready && last[m_sel]) begin
      m_busy = 1'b0;
      m_ptr  = (m_sel + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string n, input bit r, input logic [3:0] q, input logic [3:0] l, input bit rd,
                        input logic [3:0] eg, input logic [1:0] es, input bit eb, input bit ev, input bit el);
    vec_t v;
    v.name = n; v.rst = r; v.req = q; v.last = l; v.ready = rd;
    v.exp_gnt = eg; v.exp_sel = es; v.exp_busy = eb; v.exp_valid = ev; v.exp_last = el;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] rq;
    logic [3:0] rl;

    // reset, then round-robin with single-beat packets and a bubble after each
    addVec("rst_hold",  1, 4'hF, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    addVec("rst_rel",   0, 4'hF, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    addVec("rr_g0",     0, 4'hF, 4'hF, 1, 4'b0001, 0, 1, 1, 1);
    addVec("rr_b0",     0, 4'hF, 4'hF, 1, 4'b0000, 0, 0, 0, 0);
    addVec("rr_g1",     0, 4'hF, 4'hF, 1, 4'b0010, 1, 1, 1, 1);
    addVec("rr_b1",     0, 4'hF, 4'hF, 1, 4'b0000, 1, 0, 0, 0);
    addVec("rr_g2",     0, 4'hF, 4'hF, 1, 4'b0100, 2, 1, 1, 1);
    addVec("rr_b2",     0, 4'hF, 4'hF, 1, 4'b0000, 2, 0, 0, 0);
    addVec("rr_g3",     0, 4'hF, 4'hF, 1, 4'b1000, 3, 1, 1, 1);
    addVec("rr_b3",     0, 4'hF, 4'hF, 1, 4'b0000, 3, 0, 0, 0);
    addVec("rr_g0w",    0, 4'hF, 4'hF, 1, 4'b0001, 0, 1, 1, 1);
    // packet lock: requester 2 wins from ptr=1 and holds for 4 beats while req[0] stays high
    addVec("lk_idle",   0, 4'b0101, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    addVec("lk_beat1",  0, 4'b0101, 4'b0000, 1, 4'b0100, 2, 1, 1, 0);
    addVec("lk_beat2",  0, 4'b0101, 4'b0000, 1, 4'b0100, 2, 1, 1, 0);
    addVec("lk_beat3",  0, 4'b0101, 4'b0000, 1, 4'b0100, 2, 1, 1, 0);
    addVec("lk_beat4",  0, 4'b0101, 4'b0100, 1, 4'b0100, 2, 1, 1, 1);
    addVec("lk_bubble", 0, 4'b0101, 4'b0000, 1, 4'b0000, 2, 0, 0, 0);
    addVec("lk_wrap0",  0, 4'b0101, 4'b0001, 1, 4'b0001, 0, 1, 1, 1);
    // backpressure on requester 1
    addVec("bp_idle",   0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      addVec($sformatf("bp_hold%0d", i), 0, 4'b0010, 4'b0000, 0, 4'b0010, 1, 1, 1, 0);
    // requester stall: req[1] drops, last[1] and out_ready without req are ignored
    for (int i = 0; i < 3; i++)
      addVec($sformatf("st_drop%0d", i), 0, 4'b1101, 4'b0010, 1, 4'b0010, 1, 1, 0, 0);
    addVec("st_resume", 0, 4'hF, 4'b0010, 1, 4'b0010, 1, 1, 1, 1);
    // reset in the middle of a packet owned by requester 3
    addVec("mr_idle",   0, 4'b1000, 4'b0000, 1, 4'b0000, 1, 0, 0, 0);
    addVec("mr_beat",   0, 4'b1000, 4'b0000, 1, 4'b1000, 3, 1, 1, 0);
    addVec("mr_rst",    1, 4'b1000, 4'b0000, 1, 4'b1000, 3, 1, 1, 0);
    addVec("mr_after",  0, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0);
    addVec("mr_regnt",  0, 4'b1000, 4'b0000, 1, 4'b1000, 3, 1, 1, 0);

    rst = 1'b1; req = 4'hF; last = 4'hF; out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_busy = 1'b0;
    m_sel  = 0;
    m_ptr  = 0;

    $display("[TB] directed vectors: %0d", vecs.size());
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].last, vecs[i].ready);
      checkOutput(vecs[i].name, vecs[i].exp_gnt, vecs[i].exp_sel, vecs[i].exp_busy,
                  vecs[i].exp_valid, vecs[i].exp_last);
      checkModel({"model_", vecs[i].name});
      advance();
    end

    $display("[TB] random traffic");
    rq = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      rq = rq ^ (4'($urandom) & 4'($urandom));
      rl = 4'($urandom) & 4'($urandom);
      applyStimulus($urandom_range(0, 99) == 0, rq, rl, $urandom_range(0, 3) != 0);
      checkModel($sformatf("rand%0d", c));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of mux4 and drives its 2-bit sel.
- Four requesters compete for the shared 4-bit path through mux4 (in_0..in_3 -> out).
- A grant is held (locked) for a whole multi-beat packet and released only after the beat flagged last is accepted downstream.
- It adds the valid/ready handshake that the purely combinational mux4 lacks.

Parameters:
- PRIO_RESET, default 0: requester index (0..3) that holds highest priority after reset.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  req[i] high = requester i has a beat available on mux4 in_i.
- last  input  4  last[i] high = current beat of requester i ends its packet; sampled only with req[i].
- gnt  output  4  one-hot registered grant; all zero when idle.
- sel  output  2  registered binary index of the granted requester; connects to mux4 sel.
- out_valid  output  1  granted requester has a beat on mux4 out.
- out_last  output  1  that beat is the packet's last.
- out_ready  input  1  downstream accepts the beat this cycle.
- busy  output  1  a grant is currently held.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, priority pointer ptr=PRIO_RESET.
  - out_valid=0 and out_last=0 follow, since they are gated by busy.
  - Reset mid-packet abandons the packet; there is no completion or flush.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner w = first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: gnt=1<<w, sel=w, busy=1, state=GRANT.
  - Arbitration latency: req to gnt is 1 cycle.
- GRANT (combinational outputs):
  - out_valid = req[sel] & busy.
  - out_last = last[sel] & out_valid.
- Accept = out_valid & out_ready.
  - Accept with out_last=0: stay in GRANT, sel unchanged.
  - Accept with out_last=1: next edge gnt=0, busy=0, ptr=(sel+1) mod 4, state=IDLE.
- Exactly one idle/bubble cycle follows every packet; re-arbitration happens from IDLE on the next cycle. This is the required throughput; no back-to-back grants.
- Lock rules:
  - Grant never moves while busy=1, whatever other req bits do.
  - If the granted requester drops req mid-packet, out_valid=0 and the grant is held indefinitely. There is no timeout.
  - out_ready with out_valid=0 is ignored.
- sel and gnt change only at clk edges, so mux4 out is stable for a full cycle.
- Pointer wrap: sel=3 on the final accept gives ptr=0.
- Simultaneous events: req rising on other inputs in the same cycle as a final accept is not considered until the IDLE cycle. The arbitration there uses the updated ptr.
- last[i] without req[i] has no effect.
- Invariants (assertions):
  - gnt is one-hot or zero.
  - gnt==0 if and only if busy==0.
  - gnt == 1<<sel whenever busy=1.

Decomposition:
- Shared package mux4_pkg holds:
  - typedef sel_t (logic [1:0]).
  - typedef req_vec_t (logic [3:0]).
  - constant NUM_REQ=4.
  - enum arb_state_e {IDLE, GRANT}.
- One natural sub-module: rr_pick4, a combinational priority picker.
  - Inputs: req, ptr.
  - Outputs: winner index, any.
  - Reusable by later 4-way stages.
- Top level holds the FSM, pointer register, and handshake.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=4'b1111. Then:
  - gnt=0, sel=0, busy=0 during reset.
  - First cycle after release: gnt=4'b0001, sel=0.
- Round-robin fairness: req=4'b1111 and last=4'b1111 constant, out_ready=1. Grants in order sel=0,1,2,3,0, one grant every 2 cycles with a bubble between.
- Packet lock: req=4'b0101, requester 2 wins, last[2]=0 for 3 beats then 1, with req[0] held high throughout.
  - sel stays 2 for all 4 accepts.
  - Then gnt=0 for one cycle.
  - Then gnt=4'b0001 (ptr=3 wraps to 0).
- Backpressure: granted sel=1, out_ready=0 for 5 cycles. out_valid=1 and sel=1 hold steady; no pointer change.
- Requester stall: mid-packet req[sel] drops for 3 cycles while the others request. out_valid=0, gnt unchanged. The packet resumes when req returns.
- Reset mid-packet: rst pulse while sel=3 busy, PRIO_RESET=0. Next cycle gnt=0, ptr=0. With req=4'b1000, the following grant is gnt=4'b1000.
